// File: rtl/nco_corr_pkg.sv
// Shared types and helpers for the NCO/correlator bank.
package nco_corr_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } scan_state_t;

   // Index width for a bank of n channels (at least one bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Increment v, clamping at the largest value representable in w bits.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
      logic [31:0] max_v;
      max_v = (32'd1 << w) - 32'd1;
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/nco_corr_ch.sv
// One channel: NCO with window-aligned frequency shadow plus a saturating
// correlator. The acc output already includes the current cycle's sample,
// so the bank can snapshot it on the last cycle of the window.
module nco_corr_ch
   import nco_corr_pkg::*;
#(
   parameter int NCO_W = 13,
   parameter int ACC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig,
   input  logic [NCO_W-1:0] fcw,
   input  logic             load,
   input  logic             clear,
   output logic [ACC_W-1:0] acc
);

   logic [NCO_W-1:0] phase_q, phase_d;
   logic [NCO_W-1:0] shadow_q, shadow_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             code;
   logic             hit;

   // Next-state: phase advance, shadow load, count update (restart on clear).
   always_comb begin
      code     = phase_q[NCO_W-1];
      hit      = (sig == code);
      acc      = acc_q;
      phase_d  = phase_q;
      shadow_d = shadow_q;
      acc_d    = acc_q;
      if (en && hit) begin
         acc = ACC_W'(sat_inc(32'(acc_q), ACC_W));
      end
      if (load) begin
         shadow_d = fcw;
      end
      if (en) begin
         phase_d = phase_q + (load ? fcw : shadow_q);
         acc_d   = clear ? '0 : acc;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q  <= '0;
         shadow_q <= '0;
         acc_q    <= '0;
      end else begin
         phase_q  <= phase_d;
         shadow_q <= shadow_d;
         acc_q    <= acc_d;
      end
   end

endmodule

// File: rtl/nco_corr_bank.sv
// Bank of N_CH NCO/correlator channels with a dwell window, end-of-window
// snapshot, threshold detect and peak search reported by a one-cycle strobe.
module nco_corr_bank
   import nco_corr_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int NCO_W = 13,
   parameter int ACC_W = 8,
   parameter int DWELL = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    sig,
   input  logic [N_CH*NCO_W-1:0]   fcw,
   input  logic [ACC_W-1:0]        thr,
   output logic [N_CH-1:0]         det,
   output logic [$clog2(N_CH)-1:0] peak_idx,
   output logic [ACC_W-1:0]        peak_val,
   output logic                    stb
);

   localparam int IDX_W = idx_w(N_CH);
   localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [DW_W-1:0]  dwell_q, dwell_d;
   logic             init_q, init_d;
   logic [ACC_W-1:0] thr_q, thr_d;
   logic [ACC_W-1:0] snap_q [N_CH];
   logic [ACC_W-1:0] snap_d [N_CH];
   logic [ACC_W-1:0] acc_w  [N_CH];
   logic             win_end;
   logic             load;

   scan_state_t      state_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] best_idx_q;
   logic [ACC_W-1:0] best_val_q;
   logic [N_CH-1:0]  det_w_q;
   logic [N_CH-1:0]  det_q;
   logic [IDX_W-1:0] peak_idx_q;
   logic [ACC_W-1:0] peak_val_q;

   logic [ACC_W-1:0] cur_val;
   logic [ACC_W-1:0] nbest_val;
   logic [IDX_W-1:0] nbest_idx;
   logic [N_CH-1:0]  ndet;

   assign win_end = en && (dwell_q == DW_W'(DWELL - 1));
   // Shadows load on the first cycle out of reset and at every window end.
   assign load    = init_q || win_end;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         nco_corr_ch #(
            .NCO_W(NCO_W),
            .ACC_W(ACC_W)
         ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .sig  (sig),
            .fcw  (fcw[gi*NCO_W +: NCO_W]),
            .load (load),
            .clear(win_end),
            .acc  (acc_w[gi])
         );
      end
   endgenerate

   // Dwell counter, snapshot capture and threshold capture at window end.
   always_comb begin
      dwell_d = dwell_q;
      init_d  = 1'b0;
      thr_d   = thr_q;
      for (int k = 0; k < N_CH; k++) begin
         snap_d[k] = snap_q[k];
      end
      if (en) begin
         dwell_d = win_end ? '0 : dwell_q + DW_W'(1);
      end
      if (win_end) begin
         thr_d = thr;
         for (int k = 0; k < N_CH; k++) begin
            snap_d[k] = acc_w[k];
         end
      end
   end

   // Window bookkeeping registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_q <= '0;
         init_q  <= 1'b1;
         thr_q   <= '0;
         for (int k = 0; k < N_CH; k++) begin
            snap_q[k] <= '0;
         end
      end else begin
         dwell_q <= dwell_d;
         init_q  <= init_d;
         thr_q   <= thr_d;
         for (int k = 0; k < N_CH; k++) begin
            snap_q[k] <= snap_d[k];
         end
      end
   end

   // Scan step: strict-greater compare keeps ties on the lowest index.
   always_comb begin
      cur_val   = snap_q[idx_q];
      nbest_val = best_val_q;
      nbest_idx = best_idx_q;
      ndet      = det_w_q;
      if (cur_val > best_val_q) begin
         nbest_val = cur_val;
         nbest_idx = idx_q;
      end
      ndet[idx_q] = (cur_val >= thr_q);
   end

   // Scan FSM with registered results; everything holds while en is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         best_idx_q <= '0;
         best_val_q <= '0;
         det_w_q    <= '0;
         det_q      <= '0;
         peak_idx_q <= '0;
         peak_val_q <= '0;
      end else if (en) begin
         case (state_q)
            S_IDLE: begin
               if (win_end) begin
                  state_q    <= S_SCAN;
                  idx_q      <= '0;
                  best_idx_q <= '0;
                  best_val_q <= '0;
                  det_w_q    <= '0;
               end
            end
            S_SCAN: begin
               best_val_q <= nbest_val;
               best_idx_q <= nbest_idx;
               det_w_q    <= ndet;
               if (idx_q == IDX_W'(N_CH - 1)) begin
                  state_q    <= S_DONE;
                  det_q      <= ndet;
                  peak_idx_q <= nbest_idx;
                  peak_val_q <= nbest_val;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign stb      = (state_q == S_DONE) && en;
   assign det      = det_q;
   assign peak_idx = peak_idx_q;
   assign peak_val = peak_val_q;

endmodule

// File: tb/tb_nco_corr_bank.sv
// Directed bench for nco_corr_bank (N_CH=4, NCO_W=13, ACC_W=8, DWELL=256).
// Cycle 0 is the first cycle with rst low; window 1 ends at cycle 255 and
// its strobe appears at cycle 255+N_CH+1 = 260 when en stays high.
module tb_nco_corr_bank;

   localparam int N_CH  = 4;
   localparam int NCO_W = 13;
   localparam int ACC_W = 8;
   localparam int DWELL = 256;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  en = 1'b1;
   logic                  sig = 1'b0;
   logic [N_CH*NCO_W-1:0] fcw = '0;
   logic [ACC_W-1:0]      thr = 8'd200;
   logic [N_CH-1:0]       det;
   logic [1:0]            peak_idx;
   logic [ACC_W-1:0]      peak_val;
   logic                  stb;

   int   vectors = 0;
   int   errs    = 0;
   int   cnt     = 0;
   int   n       = 0;
   int   lo1     = -100;
   int   lo2     = -100;
   bit   sq_mode = 1'b0;
   logic sig_c   = 1'b0;
   int   at;
   int   nstb;

   nco_corr_bank #(
      .N_CH (N_CH),
      .NCO_W(NCO_W),
      .ACC_W(ACC_W),
      .DWELL(DWELL)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .sig     (sig),
      .fcw     (fcw),
      .thr     (thr),
      .det     (det),
      .peak_idx(peak_idx),
      .peak_val(peak_val),
      .stb     (stb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs for the current cycle: en gaps by schedule, sig constant or the
   // ideal period-16 square wave (bit 3 of the en-cycle count).
   task automatic drive();
      en  = !((cnt >= lo1 && cnt < lo1 + 10) || (cnt >= lo2 && cnt < lo2 + 10));
      sig = sq_mode ? n[3] : sig_c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (en && !rst) n++;
      cnt++;
      drive();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive();
      tick();
      tick();
   endtask

   task automatic release_rst();
      rst = 1'b0;
      cnt = 0;
      n   = 0;
      drive();
      #1;
   endtask

   task automatic set_fcw(input int k, input logic [NCO_W-1:0] v);
      fcw[k*NCO_W +: NCO_W] = v;
   endtask

   task automatic wait_stb(input int limit, output int seen);
      seen = -1;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (stb === 1'b1) begin
            seen = cnt;
            break;
         end
      end
   endtask

   task automatic check_result(input string tag, input int exp_at, input logic [3:0] exp_det,
                               input logic [1:0] exp_idx, input logic [7:0] exp_val);
      wait_stb(700, at);
      check({tag, "_stb_cycle"}, at, exp_at);
      check({tag, "_det"}, {28'd0, det}, {28'd0, exp_det});
      check({tag, "_peak_idx"}, {30'd0, peak_idx}, {30'd0, exp_idx});
      check({tag, "_peak_val"}, {24'd0, peak_val}, {24'd0, exp_val});
      $display("window %s: stb at cycle %0d det=%b peak_idx=%0d peak_val=%0d",
               tag, at, det, peak_idx, peak_val);
      tick();
      check({tag, "_stb_one_cycle"}, {31'd0, stb}, 32'd0);
   endtask

   initial begin
      // Test 1: code constant 0, sig=0 -> every count saturates.
      do_reset();
      check("rst_stb", {31'd0, stb}, 32'd0);
      check("rst_det", {28'd0, det}, 32'd0);
      check("rst_peak_idx", {30'd0, peak_idx}, 32'd0);
      check("rst_peak_val", {24'd0, peak_val}, 32'd0);
      release_rst();
      check_result("t1_sat", 260, 4'b1111, 2'd0, 8'd255);

      // Test 2: ch2 period 16 matched by sig in phase, others 3*2^(NCO_W-5) -> 128 each.
      do_reset();
      check("t2_rst_det", {28'd0, det}, 32'd0);
      check("t2_rst_peak_val", {24'd0, peak_val}, 32'd0);
      set_fcw(0, 13'd768);
      set_fcw(1, 13'd768);
      set_fcw(2, 13'd512);
      set_fcw(3, 13'd768);
      sq_mode = 1'b1;
      release_rst();
      check_result("t2_tone", 260, 4'b0100, 2'd2, 8'd255);

      // Test 3/4: sig=1, ch1/ch3 tie at 128, ch0/ch2 at 0, thr=128 boundary;
      // ch0 fcw changed mid-window affects only the next window.
      do_reset();
      sq_mode = 1'b0;
      sig_c   = 1'b1;
      thr     = 8'd128;
      set_fcw(0, 13'd0);
      set_fcw(1, 13'd768);
      set_fcw(2, 13'd0);
      set_fcw(3, 13'd768);
      release_rst();
      for (int i = 0; i < 100; i++) tick();
      set_fcw(0, 13'd768);
      check_result("t3_tie", 260, 4'b1010, 2'd1, 8'd128);
      check_result("t4_newfcw", 516, 4'b1011, 2'd0, 8'd128);

      // Test 5: en low for 10 cycles mid-window (100..109) and mid-scan (523..532).
      do_reset();
      set_fcw(0, 13'd0);
      lo1 = 100;
      lo2 = 523;
      release_rst();
      check_result("t5_gap_win", 270, 4'b1010, 2'd1, 8'd128);
      check_result("t5_gap_scan", 536, 4'b1010, 2'd1, 8'd128);

      // Test 6: window 3 ends at cycle 787; reset lands in the middle of its scan.
      nstb = 0;
      while (cnt < 789) begin
         tick();
         if (stb === 1'b1) nstb++;
      end
      check("t6_no_stb_before_rst", nstb, 32'd0);
      lo1 = -100;
      lo2 = -100;
      do_reset();
      check("t6_rst_stb", {31'd0, stb}, 32'd0);
      check("t6_rst_det", {28'd0, det}, 32'd0);
      check("t6_rst_peak_idx", {30'd0, peak_idx}, 32'd0);
      check("t6_rst_peak_val", {24'd0, peak_val}, 32'd0);
      release_rst();
      check_result("t6_after_rst", 260, 4'b1010, 2'd1, 8'd128);

      // Test 7: all-zero counts; thr=0 detects everything, thr=1 nothing.
      do_reset();
      set_fcw(1, 13'd0);
      set_fcw(3, 13'd0);
      thr = 8'd0;
      release_rst();
      check_result("t7_zero_thr0", 260, 4'b1111, 2'd0, 8'd0);
      thr = 8'd1;
      check_result("t7_zero_thr1", 516, 4'b0000, 2'd0, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/nco_corr_bank.md
Name: nco_corr_bank

Overview:
- Parametrised bank of N_CH NCO/correlator channels.
- Each channel correlates the 1-bit input `sig` against a square-wave code from its own NCO over a fixed dwell window.
- At the end of every window the bank snapshots all correlation counts, applies a programmable threshold, and scans for the strongest channel.
- One strobed result per window goes to the downstream UART/LED reporting logic. This replaces fixed two-tone detection with N-tone detection plus a peak search.

Parameters:
- N_CH, 4, number of channels (2..16)
- NCO_W, 13, NCO phase accumulator / frequency control word width
- ACC_W, 8, correlation counter width (saturating)
- DWELL, 256, window length in clk cycles; must satisfy DWELL >= N_CH+2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  run enable; low freezes NCOs, counters, dwell and scan
- sig  in  1  sampled input bit
- fcw  in  N_CH*NCO_W  per-channel frequency words, channel k at bits [k*NCO_W +: NCO_W]
- thr  in  ACC_W  detect threshold
- det  out  N_CH  per-channel detect flags, valid with stb
- peak_idx  out  $clog2(N_CH)  index of largest count
- peak_val  out  ACC_W  largest count
- stb  out  1  one-cycle result strobe

Behaviour:
- Reset: all phase accumulators, counters, dwell_cnt, snapshots, det, peak_idx, peak_val and stb = 0; scan FSM = S_IDLE.
- Reset mid-window or mid-scan aborts everything; no stb is issued for the aborted window.
- NCO (per channel):
  - phase <= phase + fcw_shadow, modulo 2^NCO_W.
  - code = phase[NCO_W-1].
  - fcw_shadow loads from fcw at reset release and on every window boundary, so fcw changes never take effect mid-window.
- Correlator (per channel):
  - Each en cycle, acc increments when sig == code.
  - Saturates at 2^ACC_W-1, no wrap.
- Dwell:
  - dwell_cnt counts 0..DWELL-1 on en cycles.
  - Cycle T is the one where dwell_cnt == DWELL-1 and en=1; that is the last sample of the window.
  - At T+1: snap[k] <= acc[k] including the sample from T; acc restarts so that the T+1 sample counts as 1 or 0; dwell_cnt = 0; scan starts.
- Scan FSM (S_IDLE -> S_SCAN -> S_DONE -> S_IDLE):
  - S_SCAN visits index i = 0..N_CH-1, one per en cycle.
  - best updates only on a strictly greater count, so ties resolve to the lowest index.
  - det[i] = (snap[i] >= thr), with thr sampled at snapshot time.
  - S_DONE: stb=1 for exactly one cycle; det, peak_idx and peak_val are updated in the same cycle and held until the next stb.
  - Latency: stb is asserted at T+N_CH+1 when en stays high.
  - The scan always finishes before the next window end, since DWELL >= N_CH+2, so no overrun case exists.
- en low: every state element holds. The scan FSM also pauses. stb cannot assert while en=0.
- All-zero counts: peak_idx=0, peak_val=0, det = all ones if thr=0, otherwise 0.

Decomposition:
- Shared package nco_corr_pkg:
  - scan state enum {S_IDLE, S_SCAN, S_DONE}
  - IDX_W = $clog2(N_CH) helper function
  - saturating-increment function
- Sub-module nco_corr_ch:
  - contents: one NCO, fcw_shadow, and the saturating correlator.
  - ports: clk, rst, en, sig, fcw, load, clear, acc.
  - instantiated N_CH times by generate.
- Top-level owns dwell counter, snapshots and scan FSM.

Test Plan:
- Reset then sig=0, all fcw=0 (code constant 0), DWELL=256, ACC_W=8 -> every count saturates at 255; stb at T+N_CH+1; det=4'b1111 with thr=200; peak_idx=0.
- fcw ch2 = 2^(NCO_W-4) (period 16); sig driven as the same square wave in phase; other channels fcw = 3*2^(NCO_W-5) -> peak_idx=2, peak_val=255 (saturated); det=4'b0100 with thr=200.
- Equal counts on ch1 and ch3, higher than all other channels -> peak_idx=1.
- Change fcw mid-window -> the current window result is unaffected; the next window reflects the new fcw.
- en low for 10 cycles mid-window and mid-scan -> stb delayed exactly 10 cycles; counts are identical to the uninterrupted run.
- rst pulsed during the scan -> no stb; outputs = 0; the next stb comes DWELL+N_CH+1 cycles after rst deasserts.
